load_store_unit: RTL and testbench

- Memory-stage load/store unit for the pipelined RV32I core.
- Sits between the M-stage pipeline register and a valid/ready data-memory bus.
- Produces the formatted load data consumed by the write-back result selection, and the byte-enabled store traffic.
- Stalls the pipeline while a bus transaction is outstanding.

---
 rtl/lsu_pkg.sv | 15 +
 rtl/load_store_unit_if.sv | 19 +
 rtl/load_formatter.sv | 21 ++
 rtl/load_store_unit.sv | 96 +++++++++
 tb/tb_load_store_unit.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: FSM states, RV32I load/store funct3 encodings and the access-size decode
// shared by the load/store unit and its load formatter.
package lsu_pkg;
    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_e;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    // Anything that is not a byte or halfword encoding is handled as a word.
    function automatic size_e access_size(input logic [2:0] f3);
        return f3[1:0] == F3_B[1:0] ? SZ_B : f3[1:0] == F3_H[1:0] ? SZ_H : SZ_W;
    endfunction
endpackage

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: valid/ready data-memory bus; the LSU is master, memory is slave.
interface load_store_unit_if #(parameter int ADDR_WIDTH = 32);
    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic [3:0]            mem_be;
    logic                  mem_rsp_valid;
    logic [31:0]           mem_rdata;
    modport master (
        output mem_req_valid, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_req_ready, mem_rsp_valid, mem_rdata
    );
    modport slave (
        input  mem_req_valid, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_req_ready, mem_rsp_valid, mem_rdata
    );
endinterface

// File: rtl/load_formatter.sv
// load_formatter: selects the addressed byte/halfword of a read word and sign/zero-extends it.
module load_formatter
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  a,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);
    logic [7:0]  b;
    logic [15:0] h;
    logic        sgn;
    size_e       sz;
    always_comb begin
        sz   = access_size(funct3);
        sgn  = funct3 != F3_BU && funct3 != F3_HU;
        b    = rdata[{a, 3'b000} +: 8];
        h    = a[1] ? rdata[31:16] : rdata[15:0];
        data = sz == SZ_B ? {{24{sgn & b[7]}}, b} : sz == SZ_H ? {{16{sgn & h[15]}}, h} : rdata;
    end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I memory-stage LSU driving a valid/ready data bus and stalling the pipeline.
// Define LSU_MISALIGN_TRAP_EN to suppress misaligned accesses and flag them on MisalignM.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  MemReadM,
    input  logic                  MemWriteM,
    input  logic [2:0]            Funct3M,
    input  logic [ADDR_WIDTH-1:0] ALUResultM,
    input  logic [31:0]           WriteDataM,
    output logic                  StallM,
    output logic [31:0]           ReadDataM,
    output logic                  MisalignM,
    load_store_unit_if.master     mem
);
    localparam int BE_W = DATA_WIDTH / 8;
    state_e                state_q;
    logic                  req_valid_q, we_q, mis_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q, rdata_q, fmt_data;
    logic [BE_W-1:0]       be_q, be_d;
    logic [31:0]           wdata_d;
    logic [2:0]            f3_q;
    logic [1:0]            alo_q, alo;
    logic                  access, misalign_d;
    size_e                 sz;
    always_comb begin
        access  = MemReadM | MemWriteM;
        sz      = access_size(Funct3M);
        alo     = ALUResultM[1:0];
        be_d    = sz == SZ_B ? BE_W'(4'b0001 << alo) : sz == SZ_H ? BE_W'(4'b0011 << {alo[1], 1'b0}) : '1;
        wdata_d = sz == SZ_B ? {4{WriteDataM[7:0]}} : sz == SZ_H ? {2{WriteDataM[15:0]}} : WriteDataM;
`ifdef LSU_MISALIGN_TRAP_EN
        misalign_d = (sz == SZ_H && alo[0]) || (sz == SZ_W && alo != 2'b00);
`else
        misalign_d = 1'b0;
`endif
        StallM = !rst && ((state_q == IDLE && access) || state_q == REQ || state_q == RESP);
    end
    load_formatter u_fmt (.rdata(mem.mem_rdata), .a(alo_q), .funct3(f3_q), .data(fmt_data));
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            req_valid_q <= 1'b0;
            we_q        <= 1'b0;
            mis_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            rdata_q     <= '0;
            f3_q        <= '0;
            alo_q       <= '0;
        end else begin
            mis_q <= 1'b0;
            case (state_q)
                IDLE: if (access) begin
                    addr_q  <= {ALUResultM[ADDR_WIDTH-1:2], 2'b00};
                    alo_q   <= alo;
                    f3_q    <= Funct3M;
                    we_q    <= MemWriteM;
                    be_q    <= be_d;
                    wdata_q <= wdata_d;
                    // A trapped access skips the bus and spends its DONE cycle flagging.
                    if (misalign_d) begin
                        state_q <= DONE;
                        mis_q   <= 1'b1;
                    end else begin
                        state_q     <= REQ;
                        req_valid_q <= 1'b1;
                    end
                end
                REQ: if (mem.mem_req_ready) begin
                    req_valid_q <= 1'b0;
                    state_q     <= we_q ? DONE : RESP;
                end
                RESP: if (mem.mem_rsp_valid) begin
                    rdata_q <= fmt_data;
                    state_q <= DONE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign mem.mem_req_valid = req_valid_q;
    assign mem.mem_we        = we_q;
    assign mem.mem_addr      = addr_q;
    assign mem.mem_wdata     = wdata_q;
    assign mem.mem_be        = be_q;
    assign ReadDataM         = rdata_q;
    assign MisalignM         = mis_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed vectors with a request/completion scoreboard and a memory responder.
module tb_load_store_unit;
    import lsu_pkg::*;
`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif
    typedef struct {logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; logic full;} req_t;
    typedef struct {logic [31:0] rd; logic mis; int stall;} cmp_t;
    logic clk = 1'b0, rst = 1'b1;
    logic MemReadM = 1'b0, MemWriteM = 1'b0;
    logic [2:0] Funct3M = 3'b0;
    logic [31:0] ALUResultM = 32'h0, WriteDataM = 32'h0;
    logic StallM, MisalignM;
    logic [31:0] ReadDataM;
    req_t req_q[$];
    cmp_t cmp_q[$];
    int total = 0, passed = 0, lag_cfg = 0;
    logic [31:0] last_rd = 32'h0, rsp_data = 32'h0;
    logic rsp_block = 1'b0, force_rsp = 1'b0, mon_en = 1'b1;

    load_store_unit_if #(.ADDR_WIDTH(32)) mem ();
    load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .MemReadM(MemReadM), .MemWriteM(MemWriteM), .Funct3M(Funct3M),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .StallM(StallM), .ReadDataM(ReadDataM),
        .MisalignM(MisalignM), .mem(mem)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic fail(input string name, input string what);
        total++;
        $display("FAIL %s: %s", name, what);
    endtask

    // Memory model: ready after lag_cfg wait cycles, single-beat response the cycle after a read handshake.
    initial begin
        int cnt = 0;
        logic hs;
        mem.mem_req_ready = 1'b0;
        mem.mem_rsp_valid = 1'b0;
        mem.mem_rdata     = 32'h0;
        forever begin
            @(negedge clk);
            hs = mem.mem_req_valid && mem.mem_req_ready && !mem.mem_we && !rst && !rsp_block;
            @(posedge clk);
            #1;
            mem.mem_rsp_valid = hs || force_rsp;
            mem.mem_rdata     = rsp_data;
            if (mem.mem_req_valid) begin
                mem.mem_req_ready = (cnt >= lag_cfg);
                cnt++;
            end else begin
                mem.mem_req_ready = 1'b0;
                cnt = 0;
            end
        end
    end

    // Monitor: checks every cycle a request is presented, and each completion (StallM falling).
    initial begin
        int sc = 0;
        req_t r;
        cmp_t c;
        forever begin
            @(negedge clk);
            if (rst || !mon_en) sc = 0;
            else begin
                if (mem.mem_req_valid) begin
                    if (req_q.size() == 0) fail("unexpected_req", $sformatf("got request addr %h, expected none", mem.mem_addr));
                    else begin
                        r = req_q[0];
                        chk("req_fields", {mem.mem_we, mem.mem_addr, r.full ? mem.mem_be : 4'h0, r.full ? mem.mem_wdata : 32'h0},
                            {r.we, r.addr, r.be, r.wdata});
                        if (mem.mem_req_ready) void'(req_q.pop_front());
                    end
                end
                if (StallM) sc++;
                else if (sc > 0) begin
                    if (cmp_q.size() == 0) fail("unexpected_done", $sformatf("got completion after %0d stall cycles, expected none", sc));
                    else begin
                        c = cmp_q.pop_front();
                        chk("done_rd", ReadDataM, c.rd);
                        chk("done_mis", MisalignM, c.mis);
                        chk("stall_cycles", sc, c.stall);
                    end
                    sc = 0;
                end
            end
        end
    end

    task automatic op(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] rsp, input int lag, input logic mis,
                      input logic [31:0] exp_rd, input logic [3:0] exp_be, input logic [31:0] exp_wd);
        int n = 0;
        MemReadM = rd; MemWriteM = wr; Funct3M = f3; ALUResultM = a; WriteDataM = wd;
        rsp_data = rsp; lag_cfg = lag;
        if (mis && TRAP) cmp_q.push_back('{last_rd, 1'b1, 1});
        else begin
            req_q.push_back('{wr, a & 32'hFFFF_FFFC, wr ? exp_be : 4'h0, wr ? exp_wd : 32'h0, wr});
            if (!wr) last_rd = exp_rd;
            cmp_q.push_back('{last_rd, 1'b0, (wr ? 2 : 3) + lag});
        end
        do begin
            @(negedge clk);
            n++;
        end while (StallM && n < 60);
        if (StallM) fail("op_timeout", $sformatf("StallM still high after %0d cycles at addr %h", n, a));
        @(posedge clk);
        #1;
        MemReadM = 1'b0; MemWriteM = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #2;
        chk("reset_ctrl", {mem.mem_req_valid, mem.mem_we, MisalignM, StallM}, 4'b0000);
        chk("reset_addr_be", {mem.mem_addr, mem.mem_be}, 36'h0);
        chk("reset_data", {mem.mem_wdata, ReadDataM}, 64'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        //  rd    wr    f3     addr          wdata         rsp           lag mis   exp_rd        be       exp_wdata
        op(1'b1, 1'b0, F3_B,  32'h0000_1003, 32'h0,        32'h80FF_1234, 0, 1'b0, 32'hFFFF_FF80, 4'h0,    32'h0);
        op(1'b1, 1'b0, F3_HU, 32'h0000_2002, 32'h0,        32'hBEEF_0000, 4, 1'b0, 32'h0000_BEEF, 4'h0,    32'h0);
        op(1'b0, 1'b1, F3_B,  32'h0000_3001, 32'h0000_00AB, 32'h0,        0, 1'b0, 32'h0,         4'b0010, 32'hABAB_ABAB);
        op(1'b1, 1'b0, F3_W,  32'h0000_4002, 32'h0,        32'h1122_3344, 0, 1'b1, 32'h1122_3344, 4'h0,    32'h0);
        op(1'b0, 1'b1, F3_W,  32'h0000_5004, 32'hCAFE_F00D, 32'h0,        0, 1'b0, 32'h0,         4'b1111, 32'hCAFE_F00D);
        op(1'b1, 1'b0, F3_W,  32'h0000_5004, 32'h0,        32'h0BAD_BEEF, 0, 1'b0, 32'h0BAD_BEEF, 4'h0,    32'h0);
        op(1'b0, 1'b1, F3_H,  32'h0000_6002, 32'h1234_ABCD, 32'h0,        2, 1'b0, 32'h0,         4'b1100, 32'hABCD_ABCD);
        op(1'b0, 1'b1, F3_H,  32'h0000_6003, 32'h1234_5678, 32'h0,        0, 1'b1, 32'h0,         4'b1100, 32'h5678_5678);
        op(1'b1, 1'b1, F3_W,  32'h0000_6008, 32'h0102_0304, 32'h0,        1, 1'b0, 32'h0,         4'b1111, 32'h0102_0304);
        op(1'b1, 1'b0, F3_H,  32'h0000_7000, 32'h0,        32'h0000_8001, 0, 1'b0, 32'hFFFF_8001, 4'h0,    32'h0);
        op(1'b1, 1'b0, F3_BU, 32'h0000_7002, 32'h0,        32'h00FE_0000, 0, 1'b0, 32'h0000_00FE, 4'h0,    32'h0);
        op(1'b1, 1'b0, F3_H,  32'h0000_7002, 32'h0,        32'h7FFF_0000, 3, 1'b0, 32'h0000_7FFF, 4'h0,    32'h0);
        repeat (3) @(posedge clk);
        #2;
        chk("req_queue_drained", req_q.size(), 0);
        chk("done_queue_drained", cmp_q.size(), 0);
        mon_en = 1'b0;
        // Reset while a request is waiting for ready.
        MemReadM = 1'b1; Funct3M = F3_W; ALUResultM = 32'h0000_5000; lag_cfg = 100;
        @(posedge clk);
        #2;
        chk("req_before_rst", mem.mem_req_valid, 1'b1);
        rst = 1'b1;
        #1;
        chk("rst_in_req", {mem.mem_req_valid, StallM}, 2'b00);
        @(posedge clk);
        #2;
        MemReadM = 1'b0; rst = 1'b0; lag_cfg = 0;
        @(posedge clk);
        #2;
        // Reset while a load waits for its response; a late response must be ignored.
        rsp_block = 1'b1;
        MemReadM = 1'b1; ALUResultM = 32'h0000_5000;
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("in_resp", {StallM, mem.mem_req_valid}, 2'b10);
        rst = 1'b1;
        #1;
        chk("rst_in_resp", {StallM, mem.mem_req_valid, ReadDataM}, 34'h0);
        @(posedge clk);
        #2;
        MemReadM = 1'b0; rst = 1'b0; rsp_data = 32'hDEAD_BEEF; force_rsp = 1'b1;
        @(posedge clk);
        #2;
        force_rsp = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("late_rsp_ignored", {StallM, mem.mem_req_valid, ReadDataM}, 34'h0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
